// File: rtl/game_pkg.sv
// Shared definitions for the sprite compositor.
//
// Holds the 6-bit {R[1:0],G[1:0],B[1:0]} colour constants, the sprite edge
// length, the shape indices understood by sprite_rom, and the object slot
// numbering used by sprite_renderer. It also holds the single bounding-box hit
// test that every object slot shares.
package game_pkg;

  localparam int SPRITE_SIZE = 8;

  localparam logic [5:0] BLACK  = 6'b000000;
  localparam logic [5:0] WHITE  = 6'b111111;
  localparam logic [5:0] PURPLE = 6'b100011;
  localparam logic [5:0] BLUE   = 6'b000011;
  localparam logic [5:0] RED    = 6'b110000;
  localparam logic [5:0] GREEN  = 6'b001100;

  localparam logic [1:0] SHP_PLAYER = 2'd0;
  localparam logic [1:0] SHP_WARP   = 2'd1;
  localparam logic [1:0] SHP_ENEMY  = 2'd2;

  // Object slots, in the order the renderer keeps them.
  localparam int NUM_OBJ    = 4;
  localparam int OBJ_PLAYER = 0;
  localparam int OBJ_WARP   = 1;
  localparam int OBJ_ENEMY1 = 2;
  localparam int OBJ_ENEMY2 = 3;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } obj_pos_t;

  // Shadow value before the first capture. The box starts at column 1023,
  // which is never inside active video, so nothing is drawn.
  localparam obj_pos_t OBJ_OFFSCREEN = '{x: 10'h3FF, y: 9'h1FF};

  // Bounding-box test. The right and bottom edges are computed 11 bits wide,
  // so an object near x=1023 cannot wrap around into column 0.
  function automatic logic in_box(input logic [9:0] h, input logic [9:0] v,
                                  input obj_pos_t p, input int size);
    logic [10:0] x_end;
    logic [10:0] y_end;
    x_end = {1'b0, p.x} + 11'(size);
    y_end = {2'b00, p.y} + 11'(size);
    return ({1'b0, h} >= {1'b0, p.x}) && ({1'b0, h} < x_end) &&
           ({1'b0, v} >= {2'b00, p.y}) && ({1'b0, v} < y_end);
  endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Bus between the sync generator / game logic and the sprite compositor.
//
// Signals:
//   display_on, hpos, vpos, hsync_in, vsync_in : raw video timing
//   bird_*, warp_*, enemy_one_*, enemy_two_*   : object top-left corners
//   score                                      : current score
//   rgb, hsync_out, vsync_out                  : registered pixel output
// The master modport drives the timing and game state. The slave modport is
// the renderer, which drives the pixel output.
interface sprite_renderer_if;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] bird_x;
  logic [8:0] bird_y;
  logic [9:0] warp_x;
  logic [8:0] warp_y;
  logic [9:0] enemy_one_x;
  logic [8:0] enemy_one_y;
  logic [9:0] enemy_two_x;
  logic [8:0] enemy_two_y;
  logic [7:0] score;
  logic [5:0] rgb;
  logic       hsync_out;
  logic       vsync_out;

  modport master (
    output display_on, hpos, vpos, hsync_in, vsync_in,
           bird_x, bird_y, warp_x, warp_y,
           enemy_one_x, enemy_one_y, enemy_two_x, enemy_two_y, score,
    input  rgb, hsync_out, vsync_out
  );

  modport slave (
    input  display_on, hpos, vpos, hsync_in, vsync_in,
           bird_x, bird_y, warp_x, warp_y,
           enemy_one_x, enemy_one_y, enemy_two_x, enemy_two_y, score,
    output rgb, hsync_out, vsync_out
  );
endinterface

// File: rtl/sprite_rom.sv
// Combinational 8x8 bitmap ROM.
//
// Ports:
//   shape in 2 : SHP_PLAYER (filled diamond), SHP_WARP (ring), SHP_ENEMY (X)
//   row   in 3 : bitmap row
//   bits  out 8: row bitmap; bit 7 is the leftmost column
// Shape 3 is unused and reads as all-transparent.
module sprite_rom
  import game_pkg::*;
(
  input  logic [1:0] shape,
  input  logic [2:0] row,
  output logic [7:0] bits
);

  always_comb begin
    bits = 8'h00;
    case (shape)
      SHP_PLAYER: begin
        case (row)
          3'd0:    bits = 8'h18;
          3'd1:    bits = 8'h3C;
          3'd2:    bits = 8'h7E;
          3'd3:    bits = 8'hFF;
          3'd4:    bits = 8'hFF;
          3'd5:    bits = 8'h7E;
          3'd6:    bits = 8'h3C;
          default: bits = 8'h18;
        endcase
      end
      SHP_WARP: begin
        case (row)
          3'd0:    bits = 8'h3C;
          3'd1:    bits = 8'h42;
          3'd6:    bits = 8'h42;
          3'd7:    bits = 8'h3C;
          default: bits = 8'h81;
        endcase
      end
      SHP_ENEMY: begin
        case (row)
          3'd0:    bits = 8'h81;
          3'd1:    bits = 8'h42;
          3'd2:    bits = 8'h24;
          3'd3:    bits = 8'h18;
          3'd4:    bits = 8'h18;
          3'd5:    bits = 8'h24;
          3'd6:    bits = 8'h42;
          default: bits = 8'h81;
        endcase
      end
      default: bits = 8'h00;
    endcase
  end

endmodule

// File: rtl/sprite_renderer.sv
// Pixel compositor: player, warp target, two enemies and a score bar.
//
// Ports:
//   clk   : pixel clock
//   reset : synchronous, active-high
//   vga   : sprite_renderer_if.slave. It carries the timing inputs, object
//           positions and score, and the registered rgb and delayed syncs.
// Positions and score are copied into shadow registers on the first blanking
// line (hpos==0, vpos==V_ACTIVE), so a frame always renders from a single
// consistent snapshot. The pipeline is fixed at two cycles: stage 1 holds the
// hit flags, and stage 2 holds the priority-muxed colour.
module sprite_renderer
  import game_pkg::*;
#(
  parameter int SPRITE_SIZE = 8,
  parameter int V_ACTIVE    = 480,
  parameter int BAR_ROWS    = 8
) (
  input  logic clk,
  input  logic reset,
  sprite_renderer_if.slave vga
);

  obj_pos_t obj_in [NUM_OBJ];
  obj_pos_t obj_q  [NUM_OBJ];
  obj_pos_t obj_d  [NUM_OBJ];

  logic [7:0]         score_q, score_d;
  logic [5:0]         frame_cnt_q, frame_cnt_d;
  logic               disp_q, disp_d;
  logic               hs1_q, hs1_d;
  logic               vs1_q, vs1_d;
  logic [NUM_OBJ-1:0] hit_q, hit_d;
  logic               bar_q, bar_d;
  logic [5:0]         rgb_q, rgb_d;
  logic               hs2_q, hs2_d;
  logic               vs2_q, vs2_d;

  logic               capture;
  logic [7:0]         rom_row [NUM_OBJ];
  logic [2:0]         row_off [NUM_OBJ];
  logic [2:0]         col_off [NUM_OBJ];

  assign obj_in[OBJ_PLAYER] = '{x: vga.bird_x,      y: vga.bird_y};
  assign obj_in[OBJ_WARP]   = '{x: vga.warp_x,      y: vga.warp_y};
  assign obj_in[OBJ_ENEMY1] = '{x: vga.enemy_one_x, y: vga.enemy_one_y};
  assign obj_in[OBJ_ENEMY2] = '{x: vga.enemy_two_x, y: vga.enemy_two_y};

  // One ROM per object slot. Only the low 3 bits of each offset matter, and
  // they equal the low bits of the difference, so the subtraction is 3 bits.
  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
    localparam logic [1:0] SHAPE = (i == OBJ_PLAYER) ? SHP_PLAYER :
                                   (i == OBJ_WARP)   ? SHP_WARP   : SHP_ENEMY;
    assign row_off[i] = vga.vpos[2:0] - obj_q[i].y[2:0];
    assign col_off[i] = vga.hpos[2:0] - obj_q[i].x[2:0];
    sprite_rom u_rom (
      .shape (SHAPE),
      .row   (row_off[i]),
      .bits  (rom_row[i])
    );
  end

  // Capture logic: the shadow registers and the frame counter update on the
  // first blanking line.
  always_comb begin
    capture     = (vga.hpos == 10'd0) && (vga.vpos == 10'(V_ACTIVE));
    obj_d       = obj_q;
    score_d     = score_q;
    frame_cnt_d = frame_cnt_q;
    if (capture) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        obj_d[i] = obj_in[i];
      end
      score_d     = vga.score;
      frame_cnt_d = frame_cnt_q + 6'd1;
    end
  end

  // Stage 1: per-object hit combined with the ROM bit, plus the bar flag.
  // Bit 4 of the frame counter gates the warp: 16 frames on, 16 frames off.
  always_comb begin
    disp_d = vga.display_on;
    hs1_d  = vga.hsync_in;
    vs1_d  = vga.vsync_in;
    hit_d  = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      hit_d[i] = in_box(vga.hpos, vga.vpos, obj_q[i], SPRITE_SIZE) &&
                 rom_row[i][3'd7 - col_off[i]];
    end
    hit_d[OBJ_WARP] = hit_d[OBJ_WARP] & ~frame_cnt_q[4];
    bar_d = (vga.vpos < 10'(BAR_ROWS)) && (vga.hpos[9:2] < score_q);
  end

  // Stage 2: priority mux. Blanking forces black no matter what hit.
  always_comb begin
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    if (!disp_q) begin
      rgb_d = BLACK;
    end else if (hit_q[OBJ_ENEMY1] || hit_q[OBJ_ENEMY2]) begin
      rgb_d = RED;
    end else if (hit_q[OBJ_PLAYER]) begin
      rgb_d = PURPLE;
    end else if (hit_q[OBJ_WARP]) begin
      rgb_d = BLUE;
    end else if (bar_q) begin
      rgb_d = WHITE;
    end else begin
      rgb_d = BLACK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        obj_q[i] <= OBJ_OFFSCREEN;
      end
      score_q     <= '0;
      frame_cnt_q <= '0;
      disp_q      <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      hit_q       <= '0;
      bar_q       <= 1'b0;
      rgb_q       <= BLACK;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
    end else begin
      obj_q       <= obj_d;
      score_q     <= score_d;
      frame_cnt_q <= frame_cnt_d;
      disp_q      <= disp_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      hit_q       <= hit_d;
      bar_q       <= bar_d;
      rgb_q       <= rgb_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
    end
  end

  assign vga.rgb       = rgb_q;
  assign vga.hsync_out = hs2_q;
  assign vga.vsync_out = vs2_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed testbench for sprite_renderer. A table of pixel vectors with
// hand-computed colours is checked after each capture scenario. Hand-written
// sequences cover sync delay, the mid-frame position change, warp blinking
// across a frame-counter wrap, and reset asserted mid-frame.
module tb_sprite_renderer;
  import game_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_renderer_if bus();

  sprite_renderer #(.SPRITE_SIZE(8), .V_ACTIVE(480), .BAR_ROWS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .vga   (bus)
  );

  typedef struct packed {
    logic [1:0] phase;
    logic       disp;
    logic [9:0] h;
    logic [9:0] v;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   frames   = 0;
  logic hs_pat [64];
  logic vs_pat [64];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic disp, input logic [9:0] h, input logic [9:0] v,
                               input logic hs, input logic vs);
    @(negedge clk);
    bus.display_on = disp;
    bus.hpos       = h;
    bus.vpos       = v;
    bus.hsync_in   = hs;
    bus.vsync_in   = vs;
  endtask

  // Drive one pixel, then read rgb two edges later.
  task automatic pixelCheck(input string name, input logic disp, input logic [9:0] h,
                            input logic [9:0] v, input logic [5:0] exp);
    applyStimulus(disp, h, v, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput(name, {2'b00, bus.rgb}, {2'b00, exp});
  endtask

  task automatic setObjects(input logic [9:0] bx, input logic [8:0] by,
                            input logic [9:0] wx, input logic [8:0] wy,
                            input logic [9:0] e1x, input logic [8:0] e1y,
                            input logic [9:0] e2x, input logic [8:0] e2y,
                            input logic [7:0] sc);
    bus.bird_x = bx;       bus.bird_y = by;
    bus.warp_x = wx;       bus.warp_y = wy;
    bus.enemy_one_x = e1x; bus.enemy_one_y = e1y;
    bus.enemy_two_x = e2x; bus.enemy_two_y = e2y;
    bus.score = sc;
  endtask

  task automatic doCapture();
    applyStimulus(1'b0, 10'd0, 10'd480, 1'b0, 1'b0);
    applyStimulus(1'b0, 10'd1, 10'd480, 1'b0, 1'b0);
    frames = (frames + 1) % 64;
  endtask

  task automatic runPhase(input logic [1:0] p);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == p) begin
        pixelCheck($sformatf("vec%0d(%0d,%0d)", i, vecs[i].h, vecs[i].v),
                   vecs[i].disp, vecs[i].h, vecs[i].v, vecs[i].exp);
      end
    end
  endtask

  initial begin
    // Phase 0: player (100,50), warp (300,300), enemy one (500,100), score 10
    vecs.push_back('{2'd0, 1'b1, 10'd104, 10'd50,  PURPLE});
    vecs.push_back('{2'd0, 1'b1, 10'd100, 10'd50,  BLACK});
    vecs.push_back('{2'd0, 1'b1, 10'd108, 10'd50,  BLACK});
    vecs.push_back('{2'd0, 1'b1, 10'd103, 10'd53,  PURPLE});
    vecs.push_back('{2'd0, 1'b1, 10'd107, 10'd57,  BLACK});
    vecs.push_back('{2'd0, 1'b1, 10'd104, 10'd57,  PURPLE});
    vecs.push_back('{2'd0, 1'b0, 10'd104, 10'd50,  BLACK});
    vecs.push_back('{2'd0, 1'b1, 10'd0,   10'd0,   WHITE});
    vecs.push_back('{2'd0, 1'b1, 10'd39,  10'd0,   WHITE});
    vecs.push_back('{2'd0, 1'b1, 10'd40,  10'd0,   BLACK});
    vecs.push_back('{2'd0, 1'b1, 10'd39,  10'd7,   WHITE});
    vecs.push_back('{2'd0, 1'b1, 10'd39,  10'd8,   BLACK});
    vecs.push_back('{2'd0, 1'b1, 10'd302, 10'd300, BLUE});
    vecs.push_back('{2'd0, 1'b1, 10'd300, 10'd300, BLACK});
    vecs.push_back('{2'd0, 1'b1, 10'd300, 10'd303, BLUE});
    vecs.push_back('{2'd0, 1'b1, 10'd303, 10'd303, BLACK});
    vecs.push_back('{2'd0, 1'b1, 10'd500, 10'd100, RED});
    vecs.push_back('{2'd0, 1'b1, 10'd501, 10'd100, BLACK});
    vecs.push_back('{2'd0, 1'b1, 10'd503, 10'd103, RED});
    // Phase 1: player and enemy one at (200,200), enemy two at (636,10), score 255
    vecs.push_back('{2'd1, 1'b1, 10'd203, 10'd203, RED});
    vecs.push_back('{2'd1, 1'b1, 10'd200, 10'd203, PURPLE});
    vecs.push_back('{2'd1, 1'b1, 10'd200, 10'd200, RED});
    vecs.push_back('{2'd1, 1'b1, 10'd201, 10'd200, BLACK});
    vecs.push_back('{2'd1, 1'b1, 10'd636, 10'd10,  RED});
    vecs.push_back('{2'd1, 1'b1, 10'd639, 10'd10,  BLACK});
    vecs.push_back('{2'd1, 1'b1, 10'd639, 10'd13,  RED});
    vecs.push_back('{2'd1, 1'b1, 10'd0,   10'd13,  BLACK});
    vecs.push_back('{2'd1, 1'b1, 10'd639, 10'd0,   WHITE});
    vecs.push_back('{2'd1, 1'b1, 10'd639, 10'd7,   WHITE});
    vecs.push_back('{2'd1, 1'b1, 10'd639, 10'd8,   BLACK});

    for (int i = 0; i < 64; i++) begin
      hs_pat[i] = i[0] ^ i[2];
      vs_pat[i] = i[3];
    end

    // Reset: every output is held low while the sync inputs are high.
    reset = 1'b1;
    bus.display_on = 1'b1; bus.hpos = 10'd0; bus.vpos = 10'd0;
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    setObjects(10'd0, 9'd0, 10'd0, 9'd0, 10'd0, 9'd0, 10'd0, 9'd0, 8'd255);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rgb", {2'b00, bus.rgb}, 8'h00);
    checkOutput("reset_hsync", {7'd0, bus.hsync_out}, 8'h00);
    checkOutput("reset_vsync", {7'd0, bus.vsync_out}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    frames = 0;

    // Syncs delayed exactly 2 cycles. rgb stays black before the first capture.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checkOutput($sformatf("hsync_dly%0d", i), {7'd0, bus.hsync_out}, {7'd0, hs_pat[i-2]});
        checkOutput($sformatf("vsync_dly%0d", i), {7'd0, bus.vsync_out}, {7'd0, vs_pat[i-2]});
        checkOutput($sformatf("precap_rgb%0d", i), {2'b00, bus.rgb}, 8'h00);
      end
      bus.display_on = 1'b1;
      bus.hpos = 10'(i);
      bus.vpos = 10'(i / 16);
      bus.hsync_in = hs_pat[i];
      bus.vsync_in = vs_pat[i];
    end

    setObjects(10'd100, 9'd50, 10'd300, 9'd300, 10'd500, 9'd100, 10'd1023, 9'd511, 8'd10);
    doCapture();
    runPhase(2'd0);

    setObjects(10'd200, 9'd200, 10'd1023, 9'd511, 10'd200, 9'd200, 10'd636, 9'd10, 8'd255);
    doCapture();
    runPhase(2'd1);

    // Mid-frame position change takes effect only at the next capture.
    // Enemy two near x=1023 must not wrap into column 0.
    setObjects(10'd100, 9'd250, 10'd1023, 9'd511, 10'd1023, 9'd511, 10'd1020, 9'd20, 8'd0);
    doCapture();
    pixelCheck("wrap_col0", 1'b1, 10'd0, 10'd20, BLACK);
    pixelCheck("wrap_col3", 1'b1, 10'd3, 10'd23, BLACK);
    pixelCheck("old_x_before", 1'b1, 10'd104, 10'd250, PURPLE);
    pixelCheck("line240", 1'b1, 10'd10, 10'd240, BLACK);
    bus.bird_x = 10'd400;
    pixelCheck("old_x_after", 1'b1, 10'd104, 10'd250, PURPLE);
    pixelCheck("new_x_early", 1'b1, 10'd404, 10'd250, BLACK);
    doCapture();
    pixelCheck("new_x_drawn", 1'b1, 10'd404, 10'd250, PURPLE);
    pixelCheck("old_x_gone", 1'b1, 10'd104, 10'd250, BLACK);

    // Warp blink over more than 64 captures, so the frame counter wraps.
    setObjects(10'd1023, 9'd511, 10'd300, 9'd300, 10'd1023, 9'd511, 10'd1023, 9'd511, 8'd0);
    for (int k = 0; k < 80; k++) begin
      doCapture();
      pixelCheck($sformatf("blink_f%0d", frames), 1'b1, 10'd302, 10'd300,
                 (frames[4] == 1'b0) ? BLUE : BLACK);
    end

    // Reset mid-frame: shadows and the frame counter clear.
    setObjects(10'd100, 9'd250, 10'd300, 9'd300, 10'd1023, 9'd511, 10'd1023, 9'd511, 8'd10);
    doCapture();
    pixelCheck("pre_reset_player", 1'b1, 10'd104, 10'd250, PURPLE);
    applyStimulus(1'b1, 10'd104, 10'd250, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("midreset_rgb", {2'b00, bus.rgb}, 8'h00);
    checkOutput("midreset_hsync", {7'd0, bus.hsync_out}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    frames = 0;
    pixelCheck("post_reset_player", 1'b1, 10'd104, 10'd250, BLACK);
    pixelCheck("post_reset_bar", 1'b1, 10'd0, 10'd0, BLACK);
    doCapture();
    pixelCheck("recap_player", 1'b1, 10'd104, 10'd250, PURPLE);
    pixelCheck("recap_bar", 1'b1, 10'd0, 10'd0, WHITE);
    pixelCheck("recap_warp", 1'b1, 10'd302, 10'd300, BLUE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
